reaction_timer_n: RTL and testbench
===================================

Name: reaction_timer_n

Overview:
- Parametrised N-player reaction-timer core; successor to the fixed single-player simple_machine_3 state machine.
- Sits between the board top (keys/switches already inverted to active-high) and the seven-segment decoders.
- Generates a pseudo-random arming delay, raises a GO indication, and times the first player to respond in BCD tick units.
- Detects false starts and timeouts, and reports the winning player index.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 1000, timing resolution; default is 1 ms per count.
- N_PLAYERS, 2, number of response buttons; range 1..8.
- N_DIGITS, 4, BCD digits in the elapsed-time counter; range 1..6.
- MIN_DELAY, 1000, minimum arming delay in ticks.
- DELAY_BITS, 11, random delay span; extra delay is 0..2^DELAY_BITS-1 ticks.

Ports:
- CLK_50MHZ  input  1  system clock; the only clock.
- RESET  input  1  synchronous, active-high reset.
- start_i  input  1  start/new-round request; active-high level, internally edge-detected.
- btn_i  input  N_PLAYERS  player response buttons; active-high level, internally edge-detected.
- time_bcd_o  output  4*N_DIGITS  elapsed time in BCD; digit 0 in [3:0].
- best_bcd_o  output  4*N_DIGITS  best valid time so far (see Optional Feature).
- winner_o  output  WIDX  index of the responding or fouling player; WIDX = N_PLAYERS>1 ? $clog2(N_PLAYERS) : 1.
- go_o  output  1  GO lamp.
- armed_o  output  1  waiting random delay.
- done_o  output  1  round finished with a valid response.
- foul_o  output  1  false start.
- timeout_o  output  1  counter saturated with no response.

Behaviour:
- All state is updated on the rising edge of CLK_50MHZ. RESET is synchronous, active-high, and wins over everything else, including mid-round.
- Reset values:
  - state = IDLE; all status outputs = 0.
  - time_bcd_o = 0; best_bcd_o = all-9s; winner_o = 0.
  - LFSR = 16'hACE1; edge-detect registers = 0.
- Edge detect: a rise is the input high this cycle and low in the previous registered sample. The state reacts to a rise sampled at edge t; outputs change at edge t+1 (1-cycle latency).
- Tick generator:
  - Divider counts 0..CLK_HZ/TICK_HZ-1 and pulses tick on wrap.
  - Divider clears on entry to ARMED and on entry to GO, so the first tick comes exactly CLK_HZ/TICK_HZ cycles after entry.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle in every state; never all-zero.
- FSM:
  - IDLE: start rise -> ARMED. Load delay = MIN_DELAY + LFSR[DELAY_BITS-1:0]; clear time_bcd_o, winner_o, and all flags.
  - ARMED (armed_o=1): delay decrements on tick.
    - Any btn rise -> FOUL: foul_o=1, winner_o = lowest-index button rising that cycle.
    - Otherwise, delay reaching 0 on a tick -> GO.
    - A btn rise on the same edge the delay expires is a foul; the foul has priority.
  - GO (go_o=1): time_bcd_o increments by 1 BCD on each tick; each digit wraps 9->0 with carry.
    - Any btn rise -> DONE: counter frozen, winner_o = lowest rising index.
    - Counter reaching all-9s -> TIMEOUT (timeout_o=1, value held at all-9s).
    - A button rise on the same cycle as saturation is a valid DONE.
  - DONE / FOUL / TIMEOUT: outputs hold. start rise -> ARMED, same actions as from IDLE.
- start rises in ARMED or GO are ignored.
- Button rises in IDLE, DONE, FOUL and TIMEOUT are ignored.
- Held buttons never retrigger; they must fall and rise again.
- At most one of go_o, armed_o, done_o, foul_o, timeout_o is high at any time.

Optional Feature:
- Macro: REACTION_BEST_TIME_EN.
- Defined:
  - On entry to DONE, if time_bcd < best_bcd_o, best_bcd_o takes the new time; it updates 1 cycle after DONE asserts.
  - Comparison is by BCD magnitude, most significant digit first.
  - Foul and timeout rounds never update best_bcd_o.
  - Only RESET returns it to all-9s.
- Undefined: best_bcd_o is tied to all-9s; no compare logic is built.

Test Plan:
- Bench configuration: CLK_HZ=100, TICK_HZ=10 (tick every 10 cycles), MIN_DELAY=3, DELAY_BITS=2, N_DIGITS=2, N_PLAYERS=3.
- Normal round: reset, start pulse -> armed_o on the next cycle; go_o rises 30..60 cycles after armed_o. btn[1] rises 47 cycles after go_o -> done_o=1, time_bcd_o=8'h04, winner_o=1, go_o=0.
- Simultaneous press: btn[2] and btn[0] rise on the same cycle in GO -> winner_o=0. Holding btn[2] afterwards causes no change.
- False start: btn[2] rises 5 cycles after armed_o -> foul_o=1, winner_o=2, go_o never asserts. A new start pulse -> armed_o=1, foul_o=0.
- Timeout: no press in GO for 990 cycles -> time_bcd_o=8'h99, timeout_o=1. A later btn rise -> no change.
- Reset mid-GO: RESET high for 1 cycle -> next cycle all flags 0, time_bcd_o=0, state IDLE; a btn rise is then ignored.
- Best time (macro defined): valid rounds at 8'h12, 8'h07, 8'h09, plus one foul -> best_bcd_o = 8'h12, then 8'h07, then stays 8'h07. Macro undefined -> best_bcd_o stays 8'h99 throughout.

Source files
------------

// File: rtl/reaction_timer_n.sv
// N-player reaction-timer core: LFSR arming delay, GO lamp, BCD elapsed time, foul/timeout.
// Define REACTION_BEST_TIME_EN to build the best-time register; otherwise best_bcd_o is all-9s.
module reaction_timer_n #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned TICK_HZ    = 1000,
  parameter int unsigned N_PLAYERS  = 2,
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned MIN_DELAY  = 1000,
  parameter int unsigned DELAY_BITS = 11,
  localparam int unsigned WIDX      = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                  CLK_50MHZ,
  input  logic                  RESET,
  input  logic                  start_i,
  input  logic [N_PLAYERS-1:0]  btn_i,
  output logic [4*N_DIGITS-1:0] time_bcd_o,
  output logic [4*N_DIGITS-1:0] best_bcd_o,
  output logic [WIDX-1:0]       winner_o,
  output logic                  go_o,
  output logic                  armed_o,
  output logic                  done_o,
  output logic                  foul_o,
  output logic                  timeout_o
);

  localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DLY_MAX = MIN_DELAY + (1 << DELAY_BITS) - 1;
  localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);
  localparam int unsigned TW      = 4 * N_DIGITS;
  localparam logic [TW-1:0] ALL9  = {N_DIGITS{4'h9}};

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StGo,
    StDone,
    StFoul,
    StTimeout
  } state_e;

  state_e                state_q, state_d;
  logic                  start_s_q, start_p_q;
  logic [N_PLAYERS-1:0]  btn_s_q, btn_p_q;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [DLY_W-1:0]      delay_q, delay_d;
  logic [TW-1:0]         time_q, time_d, time_inc;
  logic [WIDX-1:0]       winner_q, winner_d, lowest;
  logic                  go_q, armed_q, done_q, foul_q, timeout_q;
  logic                  go_d, armed_d, done_d, foul_d, timeout_d;
  logic                  start_rise, tick, enter_timed, carry;
  logic [N_PLAYERS-1:0]  btn_rise;

  assign start_rise = start_s_q & ~start_p_q;
  assign btn_rise   = btn_s_q & ~btn_p_q;
  assign tick       = (div_q == DIV_W'(DIV - 1));
  assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    lowest = '0;
    for (int i = int'(N_PLAYERS) - 1; i >= 0; i--) begin
      if (btn_rise[i]) lowest = WIDX'(i);
    end
  end

  // Ripple BCD increment, digit 0 first.
  always_comb begin
    time_inc = time_q;
    carry    = 1'b1;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (carry) begin
        if (time_q[4*i +: 4] == 4'd9) begin
          time_inc[4*i +: 4] = 4'd0;
        end else begin
          time_inc[4*i +: 4] = time_q[4*i +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    winner_d = winner_q;
    delay_d  = delay_q;
    case (state_q)
      StIdle, StDone, StFoul, StTimeout: begin
        if (start_rise) begin
          state_d  = StArmed;
          delay_d  = DLY_W'(MIN_DELAY) + DLY_W'(lfsr_q[DELAY_BITS-1:0]);
          time_d   = '0;
          winner_d = '0;
        end
      end
      StArmed: begin
        // A press on the expiry edge still counts as a false start.
        if (|btn_rise) begin
          state_d  = StFoul;
          winner_d = lowest;
        end else if (tick) begin
          if (delay_q <= DLY_W'(1)) begin
            state_d = StGo;
            delay_d = '0;
          end else begin
            delay_d = delay_q - DLY_W'(1);
          end
        end
      end
      StGo: begin
        if (|btn_rise) begin
          state_d  = StDone;
          winner_d = lowest;
        end else if (tick) begin
          time_d = time_inc;
          if (time_inc == ALL9) state_d = StTimeout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign enter_timed = (state_d != state_q) && ((state_d == StArmed) || (state_d == StGo));
  assign div_d       = (enter_timed || tick) ? '0 : div_q + DIV_W'(1);

  assign go_d      = (state_d == StGo);
  assign armed_d   = (state_d == StArmed);
  assign done_d    = (state_d == StDone);
  assign foul_d    = (state_d == StFoul);
  assign timeout_d = (state_d == StTimeout);

  always_ff @(posedge CLK_50MHZ) begin
    if (RESET) begin
      state_q   <= StIdle;
      start_s_q <= 1'b0;
      start_p_q <= 1'b0;
      btn_s_q   <= '0;
      btn_p_q   <= '0;
      lfsr_q    <= 16'hACE1;
      div_q     <= '0;
      delay_q   <= '0;
      time_q    <= '0;
      winner_q  <= '0;
      go_q      <= 1'b0;
      armed_q   <= 1'b0;
      done_q    <= 1'b0;
      foul_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_s_q <= start_i;
      start_p_q <= start_s_q;
      btn_s_q   <= btn_i;
      btn_p_q   <= btn_s_q;
      lfsr_q    <= lfsr_d;
      div_q     <= div_d;
      delay_q   <= delay_d;
      time_q    <= time_d;
      winner_q  <= winner_d;
      go_q      <= go_d;
      armed_q   <= armed_d;
      done_q    <= done_d;
      foul_q    <= foul_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef REACTION_BEST_TIME_EN
  logic          done_entry_q, done_entry_d;
  logic [TW-1:0] best_q, best_d;

  assign done_entry_d = (state_d == StDone) && (state_q != StDone);

  // Packed BCD orders the same as its decimal value, so a plain compare works.
  always_comb begin
    best_d = best_q;
    if (done_entry_q && (time_q < best_q)) best_d = time_q;
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RESET) begin
      done_entry_q <= 1'b0;
      best_q       <= ALL9;
    end else begin
      done_entry_q <= done_entry_d;
      best_q       <= best_d;
    end
  end

  assign best_bcd_o = best_q;
`else
  assign best_bcd_o = ALL9;
`endif

  assign time_bcd_o = time_q;
  assign winner_o   = winner_q;
  assign go_o       = go_q;
  assign armed_o    = armed_q;
  assign done_o     = done_q;
  assign foul_o     = foul_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_reaction_timer_n.sv
// Self-checking bench for reaction_timer_n: randomized rounds against a tick-arithmetic model.
module tb_reaction_timer_n;

  localparam int unsigned NP = 3;
  localparam int unsigned ND = 2;

`ifdef REACTION_BEST_TIME_EN
  localparam bit BestEn = 1'b1;
`else
  localparam bit BestEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [NP-1:0]   btn;
  logic [4*ND-1:0] time_bcd, best_bcd;
  logic [1:0]      winner;
  logic            go, armed, done, foul, timeout;
  logic [4:0]      status;

  int n_checks = 0;
  int n_fail   = 0;
  int best_m   = 99;

  always #5 clk = ~clk;

  assign status = {go, armed, done, foul, timeout};

  reaction_timer_n #(
    .CLK_HZ    (100),
    .TICK_HZ   (10),
    .N_PLAYERS (NP),
    .N_DIGITS  (ND),
    .MIN_DELAY (3),
    .DELAY_BITS(2)
  ) dut (
    .CLK_50MHZ (clk),
    .RESET     (rst),
    .start_i   (start),
    .btn_i     (btn),
    .time_bcd_o(time_bcd),
    .best_bcd_o(best_bcd),
    .winner_o  (winner),
    .go_o      (go),
    .armed_o   (armed),
    .done_o    (done),
    .foul_o    (foul),
    .timeout_o (timeout)
  );

  // Status encoding used below: {go, armed, done, foul, timeout}.
  localparam logic [4:0] SIdle = 5'b00000, SGo = 5'b10000, SArmed = 5'b01000;
  localparam logic [4:0] SDone = 5'b00100, SFoul = 5'b00010, STout = 5'b00001;

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic logic [1:0] lowest(input logic [2:0] m);
    for (int i = 0; i < 3; i++) if (m[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic logic [7:0] best_exp();
    return BestEn ? to_bcd(best_m) : 8'h99;
  endfunction

  // Start pulse; returns on the edge where the rise takes effect.
  task automatic do_start();
    start = 1'b1;
    wait_edges(1);
    start = 1'b0;
    wait_edges(1);
  endtask

  task automatic wait_go(output int cnt, output bit ok);
    cnt = 0;
    ok  = 1'b0;
    while (!ok && cnt < 100) begin
      wait_edges(1);
      cnt++;
      if (go) ok = 1'b1;
    end
  endtask

  task automatic release_btns();
    btn = '0;
    wait_edges(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; btn = '0;
    wait_edges(3);
    n_checks++; if (status !== SIdle) begin n_fail++; $display("FAIL reset_status got %b want %b", status, SIdle); end
    n_checks++; if (time_bcd !== 8'h00) begin n_fail++; $display("FAIL reset_time got %h want 00", time_bcd); end
    n_checks++; if (best_bcd !== 8'h99) begin n_fail++; $display("FAIL reset_best got %h want 99", best_bcd); end
    n_checks++; if (winner !== 2'd0) begin n_fail++; $display("FAIL reset_winner got %0d want 0", winner); end
    rst = 1'b0;
    best_m = 99;
    wait_edges(2);
  endtask

  task automatic test_normal();
    int cnt; bit ok; int a;
    do_start();
    n_checks++; if (status !== SArmed) begin n_fail++; $display("FAIL normal_armed got %b want %b", status, SArmed); end
    n_checks++; if (time_bcd !== 8'h00) begin n_fail++; $display("FAIL normal_clear got %h want 00", time_bcd); end
    wait_go(cnt, ok);
    n_checks++;
    if (!(ok && cnt >= 30 && cnt <= 60 && cnt % 10 == 0)) begin
      n_fail++; $display("FAIL normal_go_delay got %0d cycles want 30..60 step 10", cnt);
    end
    a = 47;
    wait_edges(a - 2);
    btn = 3'b010;
    wait_edges(2);
    n_checks++; if (status !== SDone) begin n_fail++; $display("FAIL normal_done got %b want %b", status, SDone); end
    n_checks++; if (time_bcd !== to_bcd((a - 1) / 10)) begin n_fail++; $display("FAIL normal_time got %h want %h", time_bcd, to_bcd((a - 1) / 10)); end
    n_checks++; if (winner !== 2'd1) begin n_fail++; $display("FAIL normal_winner got %0d want 1", winner); end
    if ((a - 1) / 10 < best_m) best_m = (a - 1) / 10;
    release_btns();
  endtask

  task automatic test_simultaneous();
    int cnt; bit ok; int a; logic [7:0] t_exp;
    do_start();
    wait_go(cnt, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL simul_go got %0d want go within 100", cnt); end
    a = int'($urandom_range(2, 120));
    wait_edges(a - 2);
    btn = 3'b101;
    wait_edges(2);
    t_exp = to_bcd((a - 1) / 10);
    n_checks++; if (status !== SDone) begin n_fail++; $display("FAIL simul_done got %b want %b", status, SDone); end
    n_checks++; if (winner !== 2'd0) begin n_fail++; $display("FAIL simul_winner got %0d want 0", winner); end
    n_checks++; if (time_bcd !== t_exp) begin n_fail++; $display("FAIL simul_time got %h want %h", time_bcd, t_exp); end
    if ((a - 1) / 10 < best_m) best_m = (a - 1) / 10;
    btn = 3'b100;
    wait_edges(20);
    n_checks++;
    if (status !== SDone || winner !== 2'd0 || time_bcd !== t_exp) begin
      n_fail++; $display("FAIL simul_hold got %b/%0d/%h want %b/0/%h", status, winner, time_bcd, SDone, t_exp);
    end
    release_btns();
  endtask

  task automatic test_false_start();
    int k; logic [2:0] m; bit seen_go; int cnt; bit ok;
    do_start();
    for (int r = 0; r < 3; r++) begin
      k = (r == 0) ? 3 : int'($urandom_range(0, 28));
      m = (r == 0) ? 3'b100 : 3'($urandom_range(1, 7));
      wait_edges(k);
      btn = m;
      wait_edges(2);
      n_checks++; if (status !== SFoul) begin n_fail++; $display("FAIL foul_status r%0d got %b want %b", r, status, SFoul); end
      n_checks++; if (winner !== lowest(m)) begin n_fail++; $display("FAIL foul_winner r%0d got %0d want %0d", r, winner, lowest(m)); end
      seen_go = 1'b0;
      for (int i = 0; i < 80; i++) begin
        wait_edges(1);
        if (go) seen_go = 1'b1;
      end
      n_checks++; if (seen_go !== 1'b0) begin n_fail++; $display("FAIL foul_no_go r%0d got go=1 want 0", r); end
      release_btns();
      do_start();
      n_checks++; if (status !== SArmed) begin n_fail++; $display("FAIL foul_restart r%0d got %b want %b", r, status, SArmed); end
    end
    wait_go(cnt, ok);
    btn = 3'b001;
    wait_edges(2);
    n_checks++; if (status !== SDone) begin n_fail++; $display("FAIL foul_close got %b want %b", status, SDone); end
    if ((cnt >= 0) && ok && 0 < best_m) best_m = 0;
    release_btns();
  endtask

  task automatic test_random_rounds();
    int cnt; bit ok; int a; logic [2:0] m;
    for (int r = 0; r < 5; r++) begin
      do_start();
      wait_go(cnt, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_go r%0d got %0d want go within 100", r, cnt); end
      a = int'($urandom_range(2, 300));
      m = 3'($urandom_range(1, 7));
      wait_edges(a - 2);
      btn = m;
      wait_edges(2);
      n_checks++;
      if (status !== SDone || winner !== lowest(m) || time_bcd !== to_bcd((a - 1) / 10)) begin
        n_fail++;
        $display("FAIL rand_round r%0d got %b/%0d/%h want %b/%0d/%h", r, status, winner, time_bcd,
                 SDone, lowest(m), to_bcd((a - 1) / 10));
      end
      if ((a - 1) / 10 < best_m) best_m = (a - 1) / 10;
      release_btns();
    end
  endtask

  task automatic test_timeout();
    int cnt; bit ok;
    do_start();
    wait_go(cnt, ok);
    wait_edges(989);
    n_checks++;
    if (status !== SGo || time_bcd !== 8'h98) begin
      n_fail++; $display("FAIL tout_before got %b/%h want %b/98", status, time_bcd, SGo);
    end
    wait_edges(1);
    n_checks++; if (status !== STout) begin n_fail++; $display("FAIL tout_status got %b want %b", status, STout); end
    n_checks++; if (time_bcd !== 8'h99) begin n_fail++; $display("FAIL tout_time got %h want 99", time_bcd); end
    btn = 3'b010;
    wait_edges(5);
    n_checks++;
    if (status !== STout || time_bcd !== 8'h99 || winner !== 2'd0) begin
      n_fail++; $display("FAIL tout_hold got %b/%h/%0d want %b/99/0", status, time_bcd, winner, STout);
    end
    release_btns();
  endtask

  task automatic test_reset_mid_go();
    int cnt; bit ok;
    do_start();
    wait_go(cnt, ok);
    wait_edges(int'($urandom_range(5, 60)));
    rst = 1'b1;
    wait_edges(1);
    rst = 1'b0;
    best_m = 99;
    n_checks++; if (status !== SIdle) begin n_fail++; $display("FAIL rstgo_status got %b want %b", status, SIdle); end
    n_checks++;
    if (time_bcd !== 8'h00 || winner !== 2'd0 || best_bcd !== 8'h99) begin
      n_fail++; $display("FAIL rstgo_values got %h/%0d/%h want 00/0/99", time_bcd, winner, best_bcd);
    end
    btn = 3'b001;
    wait_edges(5);
    n_checks++;
    if (status !== SIdle || time_bcd !== 8'h00) begin
      n_fail++; $display("FAIL rstgo_btn_ignored got %b/%h want %b/00", status, time_bcd, SIdle);
    end
    release_btns();
  endtask

  task automatic test_best_time();
    int plan [4] = '{12, -1, 7, 9};
    int cnt; bit ok; int a; logic [7:0] b_exp;
    for (int r = 0; r < 4; r++) begin
      do_start();
      if (plan[r] < 0) begin
        wait_edges(5);
        btn = 3'b100;
        wait_edges(2);
        n_checks++; if (status !== SFoul) begin n_fail++; $display("FAIL best_foul got %b want %b", status, SFoul); end
        wait_edges(3);
        b_exp = best_exp();
        n_checks++; if (best_bcd !== b_exp) begin n_fail++; $display("FAIL best_after_foul got %h want %h", best_bcd, b_exp); end
      end else begin
        wait_go(cnt, ok);
        a = 10 * plan[r] + int'($urandom_range(1, 10));
        wait_edges(a - 2);
        btn = 3'($urandom_range(1, 7));
        wait_edges(2);
        n_checks++;
        if (status !== SDone || time_bcd !== to_bcd(plan[r])) begin
          n_fail++; $display("FAIL best_round r%0d got %b/%h want %b/%h", r, status, time_bcd, SDone, to_bcd(plan[r]));
        end
        b_exp = best_exp();
        n_checks++; if (best_bcd !== b_exp) begin n_fail++; $display("FAIL best_pre r%0d got %h want %h", r, best_bcd, b_exp); end
        wait_edges(1);
        if ((a - 1) / 10 < best_m) best_m = (a - 1) / 10;
        b_exp = best_exp();
        n_checks++; if (best_bcd !== b_exp) begin n_fail++; $display("FAIL best_post r%0d got %h want %h", r, best_bcd, b_exp); end
      end
      release_btns();
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_simultaneous();
    test_false_start();
    test_random_rounds();
    test_timeout();
    test_reset_mid_go();
    test_best_time();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
